rob_multi: RTL

ROB_MULTI -- requirements
Module: rob_multi

---
 rtl/rob_multi_if.sv | 58 +++++
 rtl/rob_multi.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rob_multi_if.sv
// Reorder-buffer port bundle: dispatch, completion, branch resolve,
// flush and retire signals between the core and rob_multi.
interface rob_multi_if #(
  parameter int DEPTH    = 32,
  parameter int WB_PORTS = 3,
  parameter int RETIRE_W = 2,
  parameter int PREG_W   = 7,
  parameter int PC_W     = 32
);
  localparam int TAG_W = $clog2(DEPTH);

  logic                       alloc_valid;
  logic [PREG_W-1:0]          alloc_pd_new;
  logic [PREG_W-1:0]          alloc_pd_old;
  logic                       alloc_has_dest;
  logic [PC_W-1:0]            alloc_pc;
  logic                       alloc_ready;
  logic [TAG_W-1:0]           alloc_tag;
  logic [WB_PORTS-1:0]        wb_valid;
  logic [WB_PORTS*TAG_W-1:0]  wb_tag;
  logic                       br_valid;
  logic [TAG_W-1:0]           br_tag;
  logic                       br_mispredict;
  logic                       flush_valid;
  logic [TAG_W-1:0]           flush_tag;
  logic [RETIRE_W-1:0]        retire_valid;
  logic [RETIRE_W-1:0]        retire_has_dest;
  logic [RETIRE_W*PREG_W-1:0] retire_pd_old;
  logic [RETIRE_W*PC_W-1:0]   retire_pc;
  logic [TAG_W-1:0]           head_tag;
  logic [TAG_W:0]             count;
  logic                       empty;
  logic                       full;

  modport master (
    output alloc_valid, alloc_pd_new, alloc_pd_old,
    output alloc_has_dest, alloc_pc,
    output wb_valid, wb_tag,
    output br_valid, br_tag, br_mispredict,
    input  alloc_ready, alloc_tag,
    input  flush_valid, flush_tag,
    input  retire_valid, retire_has_dest,
    input  retire_pd_old, retire_pc,
    input  head_tag, count, empty, full
  );

  modport slave (
    input  alloc_valid, alloc_pd_new, alloc_pd_old,
    input  alloc_has_dest, alloc_pc,
    input  wb_valid, wb_tag,
    input  br_valid, br_tag, br_mispredict,
    output alloc_ready, alloc_tag,
    output flush_valid, flush_tag,
    output retire_valid, retire_has_dest,
    output retire_pd_old, retire_pc,
    output head_tag, count, empty, full
  );
endinterface

// File: rtl/rob_multi.sv
// Circular reorder buffer: multi-port completion, in-order multi-wide
// retire, and branch-mispredict squash of younger entries.
module rob_multi #(
  parameter int DEPTH    = 32,
  parameter int WB_PORTS = 3,
  parameter int RETIRE_W = 2,
  parameter int PREG_W   = 7,
  parameter int PC_W     = 32
) (
  input logic        clk,
  input logic        reset,
  rob_multi_if.slave rob
);
  localparam int TAG_W = $clog2(DEPTH);
  localparam int CNT_W = TAG_W + 1;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [CNT_W-1:0] cnt_t;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] done_q, done_d;
  logic [DEPTH-1:0] has_dest_q;
  logic [DEPTH-1:0][PREG_W-1:0] pd_new_q;
  logic [DEPTH-1:0][PREG_W-1:0] pd_old_q;
  logic [DEPTH-1:0][PC_W-1:0] pc_q;

  tag_t head_q, head_d;
  tag_t tail_q, tail_d;
  cnt_t count_q, count_d;
  logic flush_q, flush_d;
  tag_t ftag_q, ftag_d;

  logic [RETIRE_W-1:0] rv_q, rv_d;
  logic [RETIRE_W-1:0] rhd_q, rhd_d;
  logic [RETIRE_W*PREG_W-1:0] rpd_q, rpd_d;
  logic [RETIRE_W*PC_W-1:0] rpc_q, rpc_d;

  logic full, alloc_ready, alloc_fire, br_hit;
  tag_t br_age;
  cnt_t nret;
  logic [DEPTH-1:0] ret_sel, squash, set_done;
  logic pd_new_unused;

  // pd_new is kept per entry for rename rollback; nothing reads it yet
  assign pd_new_unused = ^pd_new_q;

  assign full = count_q == cnt_t'(DEPTH);
  assign alloc_ready = !full && !flush_q;
  assign br_hit = rob.br_valid && rob.br_mispredict
                  && valid_q[rob.br_tag];
  assign alloc_fire = rob.alloc_valid && alloc_ready && !br_hit;
  assign br_age = rob.br_tag - head_q;

  always_comb begin
    tag_t idx;
    logic run;
    idx = '0;
    run = 1'b1;
    ret_sel = '0;
    nret = '0;
    rv_d = '0;
    rhd_d = '0;
    rpd_d = '0;
    rpc_d = '0;
    for (int k = 0; k < RETIRE_W; k++) begin
      idx = head_q + tag_t'(k);
      run = run && valid_q[idx] && done_q[idx];
      if (run) begin
        ret_sel[idx] = 1'b1;
        nret = nret + cnt_t'(1);
        rv_d[k] = 1'b1;
        rhd_d[k] = has_dest_q[idx];
        rpd_d[k*PREG_W +: PREG_W] = pd_old_q[idx];
        rpc_d[k*PC_W +: PC_W] = pc_q[idx];
      end
    end
  end

  always_comb begin
    tag_t age;
    age = '0;
    squash = '0;
    set_done = '0;
    valid_d = valid_q;
    done_d = done_q;
    for (int i = 0; i < DEPTH; i++) begin
      age = tag_t'(i) - head_q;
      squash[i] = br_hit && valid_q[i] && (age > br_age);
      set_done[i] = rob.br_valid && (rob.br_tag == tag_t'(i));
      for (int p = 0; p < WB_PORTS; p++) begin
        if (rob.wb_valid[p]
            && rob.wb_tag[p*TAG_W +: TAG_W] == tag_t'(i))
          set_done[i] = 1'b1;
      end
      if (ret_sel[i] || squash[i]) begin
        valid_d[i] = 1'b0;
        done_d[i] = 1'b0;
      end else if (alloc_fire && tail_q == tag_t'(i)) begin
        valid_d[i] = 1'b1;
        done_d[i] = 1'b0;
      end else if (valid_q[i] && set_done[i]) begin
        done_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    head_d = head_q + nret[TAG_W-1:0];
    tail_d = tail_q + tag_t'(alloc_fire);
    count_d = count_q + cnt_t'(alloc_fire) - nret;
    flush_d = 1'b0;
    ftag_d = '0;
    // survivors are head..br_tag, minus whatever retires this edge
    if (br_hit) begin
      tail_d = rob.br_tag + tag_t'(1);
      count_d = cnt_t'(br_age) + cnt_t'(1) - nret;
      flush_d = 1'b1;
      ftag_d = rob.br_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      done_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      flush_q <= 1'b0;
      ftag_q <= '0;
      rv_q <= '0;
      rhd_q <= '0;
      rpd_q <= '0;
      rpc_q <= '0;
    end else begin
      valid_q <= valid_d;
      done_q <= done_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      flush_q <= flush_d;
      ftag_q <= ftag_d;
      rv_q <= rv_d;
      rhd_q <= rhd_d;
      rpd_q <= rpd_d;
      rpc_q <= rpc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      has_dest_q[tail_q] <= rob.alloc_has_dest;
      pd_new_q[tail_q] <= rob.alloc_pd_new;
      pd_old_q[tail_q] <= rob.alloc_pd_old;
      pc_q[tail_q] <= rob.alloc_pc;
    end
  end

  assign rob.alloc_ready = alloc_ready;
  assign rob.alloc_tag = tail_q;
  assign rob.flush_valid = flush_q;
  assign rob.flush_tag = ftag_q;
  assign rob.retire_valid = rv_q;
  assign rob.retire_has_dest = rhd_q;
  assign rob.retire_pd_old = rpd_q;
  assign rob.retire_pc = rpc_q;
  assign rob.head_tag = head_q;
  assign rob.count = count_q;
  assign rob.empty = count_q == '0;
  assign rob.full = full;
endmodule
